fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline, sitting directly upstream of the pre-decode logic.
- Owns the architectural fetch PC and drives the instruction bus (ibus_req_t / ibus_resp_t, valid/addr_ok/data_ok split-transaction protocol).
- Holds each returned instruction word with its PC in a one-entry output register for the decode stage.
- Handles decode back-pressure, and redirects from branch/jump resolution that discard in-flight fetches.

---
 rtl/fetch_stage_pkg.sv | 33 +++
 rtl/fetch_stage_if.sv | 10 +
 rtl/fetch_stage.sv | 114 +++++++++++
 tb/tb_fetch_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: bus request/response structs,
// fetch FSM states and the fetch-to-decode pipeline-register entry.
package fetch_stage_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } ibus_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_t;

    localparam addr_t RESET_PC = 32'hbfc0_0000;

    typedef struct packed {
        logic  valid;
        addr_t pc;
        word_t instr;
    } plr_f;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction bus between the fetch stage (master) and the memory side (slave).
interface fetch_stage_if
    import fetch_stage_pkg::*;
();
    ibus_req_t  ireq;
    ibus_resp_t iresp;

    modport master (output ireq, input  iresp);
    modport slave  (input  ireq, output iresp);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, runs one split-transaction bus
// request at a time and holds the returned word for decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter addr_t RESET_PC = fetch_stage_pkg::RESET_PC
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        ibus,
    input  logic                 redirect_valid,
    input  addr_t                redirect_pc,
    input  logic                 d_ready,
    output logic                 f_valid,
    output addr_t                f_pc,
    output word_t                f_instr
);

    fetch_state_t r_state;
    addr_t        r_pc;
    addr_t        r_req_pc;
    logic         r_discard;
    plr_f         r_out;

    logic  w_can_issue;
    logic  w_issue;
    addr_t w_issue_addr;
    logic  w_data_ok;
    logic  w_capture;

    assign w_can_issue  = !r_out.valid || d_ready || redirect_valid;
    assign w_issue      = (r_state == IDLE) && w_can_issue && !reset;
    assign w_issue_addr = redirect_valid ? redirect_pc : r_pc;
    assign w_data_ok    = (r_state == WAIT) && ibus.iresp.data_ok;
    // A redirect in the return cycle kills the word even when it is not stale.
    assign w_capture    = w_data_ok && !r_discard && !redirect_valid;

    always_comb begin
        ibus.ireq = '0;
        case (r_state)
            IDLE: begin
                ibus.ireq.valid = w_issue;
                ibus.ireq.addr  = w_issue_addr;
            end
            REQ: begin
                ibus.ireq.valid = !reset;
                ibus.ireq.addr  = r_req_pc;
            end
            default: begin
                ibus.ireq.valid = 1'b0;
                ibus.ireq.addr  = r_req_pc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_req_pc  <= RESET_PC;
            r_discard <= 1'b0;
            r_out     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_req_pc <= w_issue_addr;
                        r_state  <= ibus.iresp.addr_ok ? WAIT : REQ;
                    end
                end
                REQ: begin
                    // The request address stays frozen; a redirect only marks it stale.
                    if (ibus.iresp.addr_ok) begin
                        r_state <= WAIT;
                    end
                    if (redirect_valid) begin
                        r_discard <= 1'b1;
                    end
                end
                WAIT: begin
                    if (ibus.iresp.data_ok) begin
                        r_state   <= IDLE;
                        r_discard <= 1'b0;
                        if (w_capture) begin
                            r_pc <= r_req_pc + 32'd4;
                        end
                    end else if (redirect_valid) begin
                        r_discard <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end

            if (redirect_valid) begin
                r_out.valid <= 1'b0;
            end else if (w_capture) begin
                r_out.valid <= 1'b1;
                r_out.pc    <= r_req_pc;
                r_out.instr <= ibus.iresp.data;
            end else if (d_ready) begin
                r_out.valid <= 1'b0;
            end
        end
    end

    assign f_valid = r_out.valid;
    assign f_pc    = r_out.pc;
    assign f_instr = r_out.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a bus model with programmable handshake
// delays answers requests, a monitor pops expected entries as decode sees them.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  redirect_valid;
    addr_t redirect_pc;
    logic  d_ready;
    logic  f_valid;
    addr_t f_pc;
    word_t f_instr;

    always #5 clk = ~clk;

    fetch_stage_if ibus ();

    fetch_stage #(.RESET_PC(32'hbfc0_0000)) dut (
        .clk            (clk),
        .reset          (reset),
        .ibus           (ibus.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .d_ready        (d_ready),
        .f_valid        (f_valid),
        .f_pc           (f_pc),
        .f_instr        (f_instr)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        addr_t pc;
        word_t instr;
    } exp_t;

    exp_t  sb_q[$];
    addr_t acc_q[$];

    function automatic word_t mem(input addr_t a);
        if (a == 32'hbfc0_0000) return 32'h2408_0005;
        return a ^ 32'h5a5a_0000;
    endfunction

    task automatic expect_entry(input addr_t a);
        exp_t e;
        e.pc    = a;
        e.instr = mem(a);
        sb_q.push_back(e);
    endtask

    // Bus model knobs (written by the main sequence only)
    int aok_wait = 0;
    int dlat     = 1;
    bit force_stray = 1'b0;

    // Bus model state: decisions are made on the falling edge and seen by the DUT at the next rising edge
    int    vcnt = 0;
    int    dcnt = 0;
    bit    pend = 1'b0;
    addr_t paddr;

    always @(negedge clk) begin : bus_model
        ibus.iresp.addr_ok = 1'b0;
        ibus.iresp.data_ok = 1'b0;
        ibus.iresp.data    = 32'h0;
        if (reset) begin
            pend = 1'b0;
            vcnt = 0;
        end
        if (force_stray) begin
            ibus.iresp.data_ok = 1'b1;
            ibus.iresp.data    = 32'hdead_beef;
        end else if (pend) begin
            if (dcnt <= 1) begin
                ibus.iresp.data_ok = 1'b1;
                ibus.iresp.data    = mem(paddr);
                pend = 1'b0;
            end else begin
                dcnt--;
            end
        end
        if (!reset && ibus.ireq.valid) begin
            if (vcnt >= aok_wait) begin
                ibus.iresp.addr_ok = 1'b1;
                acc_q.push_back(ibus.ireq.addr);
                $display("[%0t] bus accept addr=%h", $time, ibus.ireq.addr);
                pend  = 1'b1;
                dcnt  = dlat;
                paddr = ibus.ireq.addr;
                vcnt  = 0;
            end else begin
                vcnt++;
            end
        end else begin
            vcnt = 0;
        end
    end

    bit   prev_valid = 1'b0;
    bit   prev_ready = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin : monitor
        if (!reset && f_valid && (!prev_valid || prev_ready)) begin
            if (sb_q.size() == 0) begin
                check("unexpected_entry", f_pc, 32'hffff_ffff);
            end else begin
                mon_e = sb_q.pop_front();
                $display("[%0t] entry pc=%h instr=%h (exp pc=%h instr=%h)",
                         $time, f_pc, f_instr, mon_e.pc, mon_e.instr);
                check("entry_pc", f_pc, mon_e.pc);
                check("entry_instr", f_instr, mon_e.instr);
            end
        end
        prev_valid = f_valid;
        prev_ready = d_ready;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_entry(input string tag);
        int k = 0;
        while (!f_valid && k < 50) begin
            step();
            k++;
        end
        check({tag, "_entry_timeout"}, f_valid, 1'b1);
    endtask

    int n0;

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        d_ready        = 1'b0;

        // Reset state
        repeat (2) step();
        settle();
        check("rst_ireq_valid", ibus.ireq.valid, 1'b0);
        check("rst_f_valid", f_valid, 1'b0);
        check("rst_f_pc", f_pc, 32'h0);
        check("rst_f_instr", f_instr, 32'h0);

        // First fetch: immediate addr_ok, data one cycle later
        aok_wait = 0;
        dlat     = 1;
        expect_entry(32'hbfc0_0000);
        reset = 1'b0;
        settle();
        check("t1_req_valid", ibus.ireq.valid, 1'b1);
        check("t1_req_addr", ibus.ireq.addr, 32'hbfc0_0000);
        step();
        check("t1_wait_no_req", ibus.ireq.valid, 1'b0);
        step();
        check("t1_f_valid", f_valid, 1'b1);

        // Back-pressure: entry held, no new request
        repeat (5) begin
            step();
            check("t3_no_req", ibus.ireq.valid, 1'b0);
            check("t3_f_pc_hold", f_pc, 32'hbfc0_0000);
        end
        expect_entry(32'hbfc0_0004);
        d_ready = 1'b1;
        settle();
        check("t3_req_valid", ibus.ireq.valid, 1'b1);
        check("t3_req_addr", ibus.ireq.addr, 32'hbfc0_0004);
        step();
        d_ready = 1'b0;
        wait_entry("t3");
        check("t1_acc0", acc_q[0], 32'hbfc0_0000);
        check("t1_acc1", acc_q[1], 32'hbfc0_0004);

        // addr_ok withheld for 3 cycles
        aok_wait = 3;
        n0 = acc_q.size();
        expect_entry(32'hbfc0_0008);
        d_ready = 1'b1;
        settle();
        check("t2_req_valid0", ibus.ireq.valid, 1'b1);
        check("t2_req_addr0", ibus.ireq.addr, 32'hbfc0_0008);
        step();
        d_ready = 1'b0;
        repeat (3) begin
            check("t2_req_valid", ibus.ireq.valid, 1'b1);
            check("t2_req_addr", ibus.ireq.addr, 32'hbfc0_0008);
            step();
        end
        check("t2_wait_no_req", ibus.ireq.valid, 1'b0);
        wait_entry("t2");
        check("t2_one_accept", acc_q.size(), n0 + 1);

        // Redirect while waiting for data: stale word dropped
        aok_wait = 0;
        dlat     = 3;
        d_ready  = 1'b1;
        settle();
        check("t4_req_addr", ibus.ireq.addr, 32'hbfc0_000c);
        step();
        d_ready = 1'b0;
        check("t4_in_wait", ibus.ireq.valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc0_0100;
        settle();
        check("t4_redir_no_req", ibus.ireq.valid, 1'b0);
        step();
        redirect_valid = 1'b0;
        n0 = acc_q.size();
        expect_entry(32'hbfc0_0100);
        wait_entry("t4");
        check("t4_one_refetch", acc_q.size(), n0 + 1);
        check("t4_refetch_addr", acc_q[n0], 32'hbfc0_0100);

        // Redirect coinciding with a live data_ok
        dlat    = 2;
        d_ready = 1'b1;
        settle();
        check("t5_req_addr", ibus.ireq.addr, 32'hbfc0_0104);
        step();
        d_ready = 1'b0;
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hbfc0_0200;
        step();
        redirect_valid = 1'b0;
        settle();
        check("t5_f_valid", f_valid, 1'b0);
        check("t5_req_valid", ibus.ireq.valid, 1'b1);
        check("t5_req_addr", ibus.ireq.addr, 32'hbfc0_0200);
        expect_entry(32'hbfc0_0200);
        wait_entry("t5");

        // Reset while in REQ, then a stray data_ok
        aok_wait = 1000;
        d_ready  = 1'b1;
        settle();
        check("t6_req_addr", ibus.ireq.addr, 32'hbfc0_0204);
        step();
        d_ready = 1'b0;
        step();
        check("t6_in_req_valid", ibus.ireq.valid, 1'b1);
        check("t6_in_req_addr", ibus.ireq.addr, 32'hbfc0_0204);
        reset = 1'b1;
        settle();
        check("t6_rst_valid", ibus.ireq.valid, 1'b0);
        step();
        reset       = 1'b0;
        force_stray = 1'b1;
        settle();
        check("t6_post_rst_valid", ibus.ireq.valid, 1'b1);
        check("t6_post_rst_addr", ibus.ireq.addr, 32'hbfc0_0000);
        step();
        force_stray = 1'b0;
        check("t6_f_valid", f_valid, 1'b0);
        check("t6_f_pc", f_pc, 32'h0);
        check("t6_f_instr", f_instr, 32'h0);
        check("t6_still_req_addr", ibus.ireq.addr, 32'hbfc0_0000);
        aok_wait = 0;
        expect_entry(32'hbfc0_0000);
        wait_entry("t6");

        repeat (3) step();
        check("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
